input_vc_buffer: RTL and testbench

Per-virtual-channel input buffer in front of the input router. It accepts flits from the link, stores them in one FIFO per VC, and presents one head flit per cycle to the input router. The router decodes route and port from the presented flit. VC selection uses fixed priority (highest VC index wins). Flits of different VCs may interleave on the output; the router keeps a per-VC routing table, so no packet lock is needed here.

---
 rtl/input_vc_buffer.sv | 109 ++++++++++
 tb/tb_input_vc_buffer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/input_vc_buffer.sv
// Per-VC input FIFOs in front of the input router; presents one head flit per cycle,
// highest non-empty VC first, first-word-fall-through.
module input_vc_buffer #(
  parameter int unsigned N_VIRT_CHN = 3,
  parameter int unsigned BUFF_DEPTH = 4,
  parameter int unsigned FLIT_WIDTH = 34
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  fin_valid_i,
  input  logic [1:0]            fin_vc_id_i,
  input  logic [FLIT_WIDTH-1:0] fin_flit_i,
  output logic [N_VIRT_CHN-1:0] fin_ready_o,
  output logic                  fout_valid_o,
  output logic [1:0]            fout_vc_id_o,
  output logic [FLIT_WIDTH-1:0] fout_flit_o,
  input  logic                  fout_ready_i,
  output logic [N_VIRT_CHN-1:0] vc_empty_o,
  output logic                  err_vc_o
);

  localparam int unsigned PtrW = $clog2(BUFF_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0]       wr_ptr_q [N_VIRT_CHN];
  logic [PtrW-1:0]       wr_ptr_d [N_VIRT_CHN];
  logic [PtrW-1:0]       rd_ptr_q [N_VIRT_CHN];
  logic [PtrW-1:0]       rd_ptr_d [N_VIRT_CHN];
  logic [CntW-1:0]       cnt_q    [N_VIRT_CHN];
  logic [CntW-1:0]       cnt_d    [N_VIRT_CHN];
  logic [FLIT_WIDTH-1:0] mem_q    [N_VIRT_CHN][BUFF_DEPTH];

  logic [N_VIRT_CHN-1:0] full, empty, push, pop;
  logic                  any_valid;
  logic [1:0]            sel;
  logic [FLIT_WIDTH-1:0] head;
  logic                  err_vc_q, err_vc_d;

  always_comb begin
    for (int v = 0; v < N_VIRT_CHN; v++) begin
      full[v]  = (cnt_q[v] == CntW'(BUFF_DEPTH));
      empty[v] = (cnt_q[v] == '0);
    end
  end

  // Ascending scan: the last non-empty VC seen (highest index) wins.
  always_comb begin
    sel  = '0;
    head = '0;
    for (int v = 0; v < N_VIRT_CHN; v++) begin
      if (!empty[v]) begin
        sel  = 2'(v);
        head = mem_q[v][rd_ptr_q[v]];
      end
    end
  end

  assign any_valid = |(~empty);

  // Gated by the reset pin so ready is low for as long as reset is held.
  assign fin_ready_o = ~full & {N_VIRT_CHN{arst}};

  always_comb begin
    for (int v = 0; v < N_VIRT_CHN; v++) begin
      push[v]     = fin_valid_i && (fin_vc_id_i == 2'(v)) && fin_ready_o[v];
      pop[v]      = any_valid && fout_ready_i && (sel == 2'(v));
      wr_ptr_d[v] = wr_ptr_q[v] + PtrW'(push[v]);
      rd_ptr_d[v] = rd_ptr_q[v] + PtrW'(pop[v]);
      unique case ({push[v], pop[v]})
        2'b10:   cnt_d[v] = cnt_q[v] + CntW'(1);
        2'b01:   cnt_d[v] = cnt_q[v] - CntW'(1);
        default: cnt_d[v] = cnt_q[v];
      endcase
    end
    err_vc_d = fin_valid_i && (32'(fin_vc_id_i) >= N_VIRT_CHN);
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      for (int v = 0; v < N_VIRT_CHN; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        cnt_q[v]    <= '0;
      end
      err_vc_q <= 1'b0;
    end else begin
      for (int v = 0; v < N_VIRT_CHN; v++) begin
        wr_ptr_q[v] <= wr_ptr_d[v];
        rd_ptr_q[v] <= rd_ptr_d[v];
        cnt_q[v]    <= cnt_d[v];
      end
      err_vc_q <= err_vc_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    for (int v = 0; v < N_VIRT_CHN; v++) begin
      if (push[v]) mem_q[v][wr_ptr_q[v]] <= fin_flit_i;
    end
  end

  assign fout_valid_o = any_valid;
  assign fout_vc_id_o = sel;
  assign fout_flit_o  = head;
  assign vc_empty_o   = empty;
  assign err_vc_o     = err_vc_q;

endmodule

// File: tb/tb_input_vc_buffer.sv
// Directed self-checking bench for input_vc_buffer.
module tb_input_vc_buffer;

  logic        clk = 1'b0;
  logic        arst = 1'b0;
  logic        fin_valid_i = 1'b0;
  logic [1:0]  fin_vc_id_i = '0;
  logic [33:0] fin_flit_i = '0;
  logic [2:0]  fin_ready_o;
  logic        fout_valid_o;
  logic [1:0]  fout_vc_id_o;
  logic [33:0] fout_flit_o;
  logic        fout_ready_i = 1'b0;
  logic [2:0]  vc_empty_o;
  logic        err_vc_o;

  int errors = 0;
  int checks = 0;

  input_vc_buffer #(
    .N_VIRT_CHN(3),
    .BUFF_DEPTH(4),
    .FLIT_WIDTH(34)
  ) dut (
    .clk(clk),
    .arst(arst),
    .fin_valid_i(fin_valid_i),
    .fin_vc_id_i(fin_vc_id_i),
    .fin_flit_i(fin_flit_i),
    .fin_ready_o(fin_ready_o),
    .fout_valid_o(fout_valid_o),
    .fout_vc_id_o(fout_vc_id_o),
    .fout_flit_o(fout_flit_o),
    .fout_ready_i(fout_ready_i),
    .vc_empty_o(vc_empty_o),
    .err_vc_o(err_vc_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] vc, input logic [33:0] f);
    fin_valid_i = 1'b1;
    fin_vc_id_i = vc;
    fin_flit_i  = f;
    tick();
    fin_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (fout_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", fout_valid_o); end
    checks++; if (fout_flit_o !== 34'h0) begin errors++; $display("FAIL rst_flit got %h exp 0", fout_flit_o); end
    checks++; if (vc_empty_o !== 3'b111) begin errors++; $display("FAIL rst_empty got %b exp 111", vc_empty_o); end
    checks++; if (fin_ready_o !== 3'b000) begin errors++; $display("FAIL rst_ready got %b exp 000", fin_ready_o); end
    checks++; if (err_vc_o !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err_vc_o); end
    #9 arst = 1'b1;
    #1;
    checks++; if (fin_ready_o !== 3'b111) begin errors++; $display("FAIL rel_ready got %b exp 111", fin_ready_o); end
    tick();
  endtask

  task automatic test_single();
    fout_ready_i = 1'b1;
    push(2'd0, 34'h0_0000_0001);
    checks++; if (fout_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", fout_valid_o); end
    checks++; if (fout_vc_id_o !== 2'd0) begin errors++; $display("FAIL single_vc got %0d exp 0", fout_vc_id_o); end
    checks++; if (fout_flit_o !== 34'h1) begin errors++; $display("FAIL single_flit got %h exp 1", fout_flit_o); end
    tick();
    checks++; if (vc_empty_o !== 3'b111) begin errors++; $display("FAIL single_empty got %b exp 111", vc_empty_o); end
    checks++; if (fout_valid_o !== 1'b0) begin errors++; $display("FAIL single_drop got %b exp 0", fout_valid_o); end
    fout_ready_i = 1'b0;
  endtask

  task automatic test_fill();
    logic [33:0] f [4];
    f[0] = 34'h0_1111_0000; f[1] = 34'h1_2222_0001; f[2] = 34'h1_3333_0002; f[3] = 34'h2_4444_0003;
    // Advance VC2 pointers by two so the fill wraps.
    push(2'd2, 34'h0_AAAA_0000);
    push(2'd2, 34'h0_BBBB_0000);
    fout_ready_i = 1'b1;
    tick();
    tick();
    fout_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) push(2'd2, f[i]);
    checks++; if (fin_ready_o !== 3'b011) begin errors++; $display("FAIL full_ready got %b exp 011", fin_ready_o); end
    push(2'd2, 34'h3_DEAD_BEEF);
    checks++; if (fin_ready_o !== 3'b011) begin errors++; $display("FAIL full_drop_ready got %b exp 011", fin_ready_o); end
    fout_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (fout_flit_o !== f[i]) begin errors++; $display("FAIL drain_flit[%0d] got %h exp %h", i, fout_flit_o, f[i]); end
      checks++; if (fout_vc_id_o !== 2'd2) begin errors++; $display("FAIL drain_vc[%0d] got %0d exp 2", i, fout_vc_id_o); end
      tick();
    end
    checks++; if (fout_valid_o !== 1'b0) begin errors++; $display("FAIL drain_valid got %b exp 0", fout_valid_o); end
    checks++; if (fout_flit_o !== 34'h0) begin errors++; $display("FAIL drain_flit0 got %h exp 0", fout_flit_o); end
    fout_ready_i = 1'b0;
  endtask

  task automatic test_priority();
    logic [33:0] f [3];
    logic [1:0]  vcs [3];
    f[0] = 34'h0_0000_000C; f[1] = 34'h3_0000_000B; f[2] = 34'h2_0000_000A;
    vcs[0] = 2'd2; vcs[1] = 2'd1; vcs[2] = 2'd0;
    push(2'd0, 34'h2_0000_000A);
    push(2'd1, 34'h3_0000_000B);
    push(2'd2, 34'h0_0000_000C);
    checks++; if (vc_empty_o !== 3'b000) begin errors++; $display("FAIL prio_empty got %b exp 000", vc_empty_o); end
    fout_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (fout_vc_id_o !== vcs[i]) begin errors++; $display("FAIL prio_vc[%0d] got %0d exp %0d", i, fout_vc_id_o, vcs[i]); end
      checks++; if (fout_flit_o !== f[i]) begin errors++; $display("FAIL prio_flit[%0d] got %h exp %h", i, fout_flit_o, f[i]); end
      tick();
    end
    checks++; if (fout_valid_o !== 1'b0) begin errors++; $display("FAIL prio_end got %b exp 0", fout_valid_o); end
    fout_ready_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [33:0] exp_q [$];
    logic [33:0] e;
    push(2'd1, 34'h1_0000_0100);
    push(2'd1, 34'h1_0000_0101);
    exp_q.push_back(34'h1_0000_0100);
    exp_q.push_back(34'h1_0000_0101);
    fout_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      fin_valid_i = 1'b1;
      fin_vc_id_i = 2'd1;
      fin_flit_i  = 34'h1_0000_0200 + 34'(i);
      exp_q.push_back(fin_flit_i);
      e = exp_q.pop_front();
      checks++; if (fout_flit_o !== e) begin errors++; $display("FAIL b2b_flit[%0d] got %h exp %h", i, fout_flit_o, e); end
      checks++; if ({fin_ready_o[1], vc_empty_o[1]} !== 2'b10) begin errors++; $display("FAIL b2b_cnt[%0d] got rdy/empty %b%b exp 10", i, fin_ready_o[1], vc_empty_o[1]); end
      tick();
    end
    fin_valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      checks++; if (fout_flit_o !== e) begin errors++; $display("FAIL b2b_tail[%0d] got %h exp %h", i, fout_flit_o, e); end
      tick();
    end
    checks++; if (fout_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_end got %b exp 0", fout_valid_o); end
    fout_ready_i = 1'b0;
  endtask

  task automatic test_bad_vc();
    push(2'd0, 34'h2_0000_0D0D);
    fin_valid_i = 1'b1;
    fin_vc_id_i = 2'd3;
    fin_flit_i  = 34'h3_0000_0E0E;
    checks++; if (err_vc_o !== 1'b0) begin errors++; $display("FAIL badvc_pre got %b exp 0", err_vc_o); end
    tick();
    fin_valid_i = 1'b0;
    checks++; if (err_vc_o !== 1'b1) begin errors++; $display("FAIL badvc_err got %b exp 1", err_vc_o); end
    checks++; if (vc_empty_o !== 3'b110) begin errors++; $display("FAIL badvc_empty got %b exp 110", vc_empty_o); end
    checks++; if (fout_flit_o !== 34'h2_0000_0D0D) begin errors++; $display("FAIL badvc_flit got %h exp 200000d0d", fout_flit_o); end
    tick();
    checks++; if (err_vc_o !== 1'b0) begin errors++; $display("FAIL badvc_pulse got %b exp 0", err_vc_o); end
    fout_ready_i = 1'b1;
    tick();
    checks++; if (fout_valid_o !== 1'b0) begin errors++; $display("FAIL badvc_drain got %b exp 0", fout_valid_o); end
    fout_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    push(2'd0, 34'h0_0000_00F1);
    push(2'd0, 34'h1_0000_00F2);
    push(2'd0, 34'h2_0000_00F3);
    checks++; if (fout_flit_o !== 34'h0_0000_00F1) begin errors++; $display("FAIL mid_pre got %h exp f1", fout_flit_o); end
    #2 arst = 1'b0;
    #1;
    checks++; if (fout_valid_o !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", fout_valid_o); end
    checks++; if (vc_empty_o !== 3'b111) begin errors++; $display("FAIL mid_empty got %b exp 111", vc_empty_o); end
    checks++; if (fin_ready_o !== 3'b000) begin errors++; $display("FAIL mid_ready got %b exp 000", fin_ready_o); end
    @(posedge clk);
    #2 arst = 1'b1;
    #1;
    checks++; if (fin_ready_o !== 3'b111) begin errors++; $display("FAIL mid_rel_ready got %b exp 111", fin_ready_o); end
    tick();
    push(2'd0, 34'h3_0000_0A5A);
    checks++; if (fout_flit_o !== 34'h3_0000_0A5A) begin errors++; $display("FAIL mid_new got %h exp 300000a5a", fout_flit_o); end
    checks++; if (vc_empty_o !== 3'b110) begin errors++; $display("FAIL mid_new_empty got %b exp 110", vc_empty_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_priority();
    test_back_to_back();
    test_bad_vc();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
